// File: rtl/temp_state_filter_if.sv
// temp_state_filter_if
//   Bundles the sample/ack inputs and the debounced outputs of temp_state_filter.
//   master : the upstream side (analyzer + software ack) that drives
//            sample_en, temp_state and fault_ack, and observes the results.
//   slave  : the filter itself.
//   Signals:
//     sample_en     - strobe, temp_state is only looked at when high
//     temp_state    - raw analyzer state (00 IDLE, 01 NORMAL, 10 WARNING, 11 FAULT)
//     fault_ack     - single-cycle request to clear fault_latched
//     stable_state  - committed (debounced) state
//     state_chg     - one-cycle pulse when stable_state changes
//     warn_alarm    - high while stable_state is WARNING or FAULT
//     fault_latched - sticky flag set on entry to FAULT
//     fault_count   - saturating count of commits into FAULT
interface temp_state_filter_if #(
  parameter int FAULT_CNT_W = 8
);
  logic                   sample_en;
  logic [1:0]             temp_state;
  logic                   fault_ack;
  logic [1:0]             stable_state;
  logic                   state_chg;
  logic                   warn_alarm;
  logic                   fault_latched;
  logic [FAULT_CNT_W-1:0] fault_count;

  modport master (
    output sample_en, temp_state, fault_ack,
    input  stable_state, state_chg, warn_alarm, fault_latched, fault_count
  );

  modport slave (
    input  sample_en, temp_state, fault_ack,
    output stable_state, state_chg, warn_alarm, fault_latched, fault_count
  );
endinterface

// File: rtl/temp_state_filter.sv
// temp_state_filter
//   Debounces the 2-bit temperature state from the analyzer. A new state is
//   committed only after DEBOUNCE_CNT consecutive enabled samples of that same
//   state; a warning alarm is decoded from the committed state, FAULT entries
//   are latched until acknowledged, and FAULT entries are counted (saturating).
//   Parameters:
//     DEBOUNCE_CNT - consecutive samples needed to commit (1..255)
//     FAULT_CNT_W  - width of the FAULT entry counter
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - temp_state_filter_if slave modport (inputs/outputs listed there)
module temp_state_filter #(
  parameter int DEBOUNCE_CNT = 4,
  parameter int FAULT_CNT_W  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  temp_state_filter_if.slave   bus
);

  localparam int              RUN_W     = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [RUN_W-1:0] DEB_LIMIT = RUN_W'(DEBOUNCE_CNT);
  localparam logic [1:0]      ST_FAULT  = 2'b11;

  typedef enum logic {
    CLEAR   = 1'b0,
    LATCHED = 1'b1
  } fault_fsm_e;

  logic [1:0]             cand_state_q, cand_state_d;
  logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
  logic [1:0]             stable_state_q, stable_state_d;
  logic                   state_chg_q, state_chg_d;
  fault_fsm_e             fault_state_q, fault_state_d;
  logic [FAULT_CNT_W-1:0] fault_count_q, fault_count_d;

  logic [RUN_W-1:0]       next_run;
  logic                   commit;
  logic                   fault_commit;

  always_comb begin
    cand_state_d   = cand_state_q;
    run_cnt_d      = run_cnt_q;
    stable_state_d = stable_state_q;
    state_chg_d    = 1'b0;
    fault_state_d  = fault_state_q;
    fault_count_d  = fault_count_q;
    next_run       = run_cnt_q;
    commit         = 1'b0;

    if (bus.sample_en) begin
      // A sample equal to the committed state kills any run in progress;
      // a different sample either extends the current candidate's run or
      // starts a fresh run of length 1 for the new candidate.
      if (bus.temp_state == stable_state_q) begin
        next_run = '0;
      end else if (bus.temp_state == cand_state_q && run_cnt_q != '0) begin
        next_run = run_cnt_q + RUN_W'(1);
      end else begin
        cand_state_d = bus.temp_state;
        next_run     = RUN_W'(1);
      end
      run_cnt_d = next_run;

      if (bus.temp_state != stable_state_q && next_run == DEB_LIMIT) begin
        commit         = 1'b1;
        stable_state_d = bus.temp_state;
        state_chg_d    = 1'b1;
        run_cnt_d      = '0;
      end
    end

    fault_commit = commit && (bus.temp_state == ST_FAULT);

    // Set has priority over ack; ack is only honoured once the committed
    // state has left FAULT, and is never remembered for later.
    if (fault_commit) begin
      fault_state_d = LATCHED;
      if (fault_count_q != '1) begin
        fault_count_d = fault_count_q + FAULT_CNT_W'(1);
      end
    end else if (fault_state_q == LATCHED && bus.fault_ack &&
                 stable_state_q != ST_FAULT) begin
      fault_state_d = CLEAR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_state_q   <= 2'b00;
      run_cnt_q      <= '0;
      stable_state_q <= 2'b00;
      state_chg_q    <= 1'b0;
      fault_state_q  <= CLEAR;
      fault_count_q  <= '0;
    end else begin
      cand_state_q   <= cand_state_d;
      run_cnt_q      <= run_cnt_d;
      stable_state_q <= stable_state_d;
      state_chg_q    <= state_chg_d;
      fault_state_q  <= fault_state_d;
      fault_count_q  <= fault_count_d;
    end
  end

  assign bus.stable_state  = stable_state_q;
  assign bus.state_chg     = state_chg_q;
  assign bus.warn_alarm    = stable_state_q[1];
  assign bus.fault_latched = (fault_state_q == LATCHED);
  assign bus.fault_count   = fault_count_q;

endmodule

// File: tb/tb_temp_state_filter.sv
// tb_temp_state_filter
//   Drives two filter instances: dut_a with default parameters
//   (DEBOUNCE_CNT=4, FAULT_CNT_W=8) and dut_b with DEBOUNCE_CNT=1,
//   FAULT_CNT_W=2 to reach counter saturation quickly.
module tb_temp_state_filter;

  logic clk;
  logic rst_n;

  temp_state_filter_if #(.FAULT_CNT_W(8)) bus_a ();
  temp_state_filter_if #(.FAULT_CNT_W(2)) bus_b ();

  temp_state_filter #(.DEBOUNCE_CNT(4), .FAULT_CNT_W(8)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  temp_state_filter #(.DEBOUNCE_CNT(1), .FAULT_CNT_W(2)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic [1:0] ts;
    logic       ack;
    int         st;
    int         chg;
    int         warn;
    int         lat;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: the run is kept as the list of trailing enabled
  // samples that differ from the committed state and are all identical.
  int m_deb;
  int m_max;
  int m_stable;
  int m_hist[$];
  int m_lat;
  int m_cnt;
  int m_chg;

  task automatic addVec(input logic en, input logic [1:0] ts, input logic ack,
                        input int st, input int chg, input int warn,
                        input int lat, input int cnt);
    vec_t v;
    v.en = en; v.ts = ts; v.ack = ack;
    v.st = st; v.chg = chg; v.warn = warn; v.lat = lat; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input int which, input string tag, input int st,
                          input int chg, input int warn, input int lat,
                          input int cnt);
    if (which == 0) begin
      checkOutput({tag, " stable_state"},  int'(bus_a.stable_state),  st);
      checkOutput({tag, " state_chg"},     int'(bus_a.state_chg),     chg);
      checkOutput({tag, " warn_alarm"},    int'(bus_a.warn_alarm),    warn);
      checkOutput({tag, " fault_latched"}, int'(bus_a.fault_latched), lat);
      checkOutput({tag, " fault_count"},   int'(bus_a.fault_count),   cnt);
    end else begin
      checkOutput({tag, " stable_state"},  int'(bus_b.stable_state),  st);
      checkOutput({tag, " state_chg"},     int'(bus_b.state_chg),     chg);
      checkOutput({tag, " warn_alarm"},    int'(bus_b.warn_alarm),    warn);
      checkOutput({tag, " fault_latched"}, int'(bus_b.fault_latched), lat);
      checkOutput({tag, " fault_count"},   int'(bus_b.fault_count),   cnt);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, and return 1 time unit
  // after it so the outputs reflect this sample.
  task automatic applyStimulus(input int which, input logic en,
                               input logic [1:0] ts, input logic ack);
    if (which == 0) begin
      bus_a.sample_en = en; bus_a.temp_state = ts; bus_a.fault_ack = ack;
    end else begin
      bus_b.sample_en = en; bus_b.temp_state = ts; bus_b.fault_ack = ack;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus_a.sample_en = 1'b0; bus_a.temp_state = 2'b00; bus_a.fault_ack = 1'b0;
    bus_b.sample_en = 1'b0; bus_b.temp_state = 2'b00; bus_b.fault_ack = 1'b0;
  endtask

  task automatic resetDut();
    idleInputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic modelInit(input int deb, input int max_cnt);
    m_deb = deb; m_max = max_cnt;
    m_stable = 0; m_hist.delete();
    m_lat = 0; m_cnt = 0; m_chg = 0;
  endtask

  task automatic modelStep(input int en, input int ts, input int ack);
    int old_stable;
    int committed;
    old_stable = m_stable;
    committed  = 0;
    m_chg      = 0;
    if (en != 0) begin
      if (ts == m_stable) begin
        m_hist.delete();
      end else begin
        if (m_hist.size() > 0 && m_hist[m_hist.size()-1] != ts) m_hist.delete();
        m_hist.push_back(ts);
        if (m_hist.size() == m_deb) begin
          m_stable  = ts;
          m_chg     = 1;
          committed = 1;
          m_hist.delete();
        end
      end
    end
    if (committed != 0 && ts == 3) begin
      m_lat = 1;
      if (m_cnt < m_max) m_cnt++;
    end else if (ack != 0 && m_lat != 0 && old_stable != 3) begin
      m_lat = 0;
    end
  endtask

  task automatic randomPhase(input int which, input int deb, input int max_cnt,
                             input int cycles);
    int ts;
    int en;
    int ack;
    resetDut();
    modelInit(deb, max_cnt);
    ts = 0;
    for (int i = 0; i < cycles; i++) begin
      en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if ($urandom_range(0, 3) == 0) ts = int'($urandom_range(0, 3));
      ack = ($urandom_range(0, 7) == 0) ? 1 : 0;
      applyStimulus(which, en[0], ts[1:0], ack[0]);
      modelStep(en, ts, ack);
      checkAll(which, $sformatf("rand%0d[%0d]", which, i), m_stable, m_chg,
               m_stable / 2, m_lat, m_cnt);
    end
    idleInputs();
  endtask

  initial begin
    idleInputs();
    rst_n = 1'b0;
    #3;
    checkAll(0, "reset_a", 0, 0, 0, 0, 0);
    checkAll(1, "reset_b", 0, 0, 0, 0, 0);
    resetDut();

    // Directed table for dut_a: columns en, ts, ack -> stable, chg, warn, lat, cnt
    for (int i = 0; i < 4; i++)
      addVec(1'b1, 2'b01, 1'b0, (i == 3) ? 1 : 0, (i == 3) ? 1 : 0, 0, 0, 0);
    addVec(1'b0, 2'b00, 1'b0, 1, 0, 0, 0, 0);
    addVec(1'b1, 2'b10, 1'b0, 1, 0, 0, 0, 0);
    addVec(1'b1, 2'b10, 1'b0, 1, 0, 0, 0, 0);
    addVec(1'b1, 2'b10, 1'b0, 1, 0, 0, 0, 0);
    addVec(1'b1, 2'b01, 1'b0, 1, 0, 0, 0, 0);
    addVec(1'b1, 2'b10, 1'b0, 1, 0, 0, 0, 0);
    addVec(1'b1, 2'b10, 1'b0, 1, 0, 0, 0, 0);
    addVec(1'b1, 2'b10, 1'b0, 1, 0, 0, 0, 0);
    addVec(1'b1, 2'b10, 1'b0, 2, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++)
      addVec((i % 2) == 0, 2'b11, 1'b0, (i == 6) ? 3 : 2, (i == 6) ? 1 : 0, 1,
             (i == 6) ? 1 : 0, (i == 6) ? 1 : 0);
    addVec(1'b0, 2'b11, 1'b1, 3, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++)
      addVec(1'b1, 2'b00, 1'b0, (i == 3) ? 0 : 3, (i == 3) ? 1 : 0,
             (i == 3) ? 0 : 1, 1, 1);
    addVec(1'b0, 2'b00, 1'b1, 0, 0, 0, 0, 1);
    addVec(1'b0, 2'b00, 1'b1, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].en, vecs[i].ts, vecs[i].ack);
      checkAll(0, $sformatf("vec[%0d]", i), vecs[i].st, vecs[i].chg,
               vecs[i].warn, vecs[i].lat, vecs[i].cnt);
    end
    idleInputs();

    // dut_b: immediate commits, fault_count saturates at 3, set beats ack.
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, 2'b11, 1'b1);
      checkAll(1, $sformatf("sat_fault[%0d]", i), 3, 1, 1, 1, (i < 3) ? i + 1 : 3);
      applyStimulus(1, 1'b1, 2'b00, 1'b1);
      checkAll(1, $sformatf("sat_idle[%0d]", i), 0, 1, 0, 1, (i < 3) ? i + 1 : 3);
      applyStimulus(1, 1'b0, 2'b00, 1'b1);
      checkAll(1, $sformatf("sat_ack[%0d]", i), 0, 0, 0, 0, (i < 3) ? i + 1 : 3);
    end
    idleInputs();

    // Reset in the middle of a run throws the partial run away.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 2'b10, 1'b0);
    checkAll(0, "midrun_pre", 0, 0, 0, 0, 0);
    idleInputs();
    rst_n = 1'b0;
    #3;
    checkAll(0, "midrun_in_reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 2'b10, 1'b0);
    checkAll(0, "midrun_one_after", 0, 0, 0, 0, 0);
    applyStimulus(0, 1'b1, 2'b10, 1'b0);
    applyStimulus(0, 1'b1, 2'b10, 1'b0);
    checkAll(0, "midrun_three_after", 0, 0, 0, 0, 0);
    applyStimulus(0, 1'b1, 2'b10, 1'b0);
    checkAll(0, "midrun_four_after", 2, 1, 1, 0, 0);
    idleInputs();

    randomPhase(0, 4, 255, 600);
    randomPhase(1, 1, 3, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
